// File: rtl/tns_tx_scheduler_pkg.sv
// tns_tx_scheduler_pkg: encoder symbol defaults and scheduler FSM encoding
// The symbol constants must track the encoder's datain width and legal range.
package tns_tx_scheduler_pkg;
    localparam int TNS_SYM_W    = 3;
    localparam int TNS_SYM_MAX  = 6;
    localparam int TNS_IDLE_SYM = 0;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2
    } tx_state_t;
endpackage

// File: rtl/tns_rr_arbiter.sv
// tns_rr_arbiter: combinational round-robin pick starting at ptr, one-hot grant plus id
// Reusable for the RX return path; gnt is zero when en is low or no request is pending.
module tns_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDW-1:0]     id
);
    logic [NUM_REQ-1:0] hi;
    logic [NUM_REQ-1:0] pool;
    always_comb begin
        // requests at or above ptr win; otherwise wrap to the lowest request
        hi   = req & ({NUM_REQ{1'b1}} << ptr);
        pool = (|hi) ? hi : req;
        id   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            id = pool[i] ? IDW'(i) : id;
        gnt  = (en && |req) ? NUM_REQ'(1) << id : '0;
    end
endmodule

// File: rtl/tns_tx_scheduler.sv
// tns_tx_scheduler: shares one TNS encoder lane between requesters, framing each word
// as an optional id header followed by LSB-first payload symbols, IDLE_SYM between frames.
module tns_tx_scheduler
    import tns_tx_scheduler_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int SYM_W        = TNS_SYM_W,
    parameter int SYM_PER_WORD = 4,
    parameter int SYM_MAX      = TNS_SYM_MAX,
    parameter int IDLE_SYM     = TNS_IDLE_SYM,
    parameter bit HDR_EN       = 1'b1,
    parameter int IDW          = $clog2(NUM_REQ)
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [NUM_REQ-1:0]                    req_valid,
    input  logic [NUM_REQ*SYM_W*SYM_PER_WORD-1:0] req_data,
    output logic [NUM_REQ-1:0]                    req_ready,
    output logic [SYM_W-1:0]                      enc_data,
    output logic                                  enc_sof,
    output logic                                  enc_active,
    output logic [IDW-1:0]                        grant_id,
    output logic                                  sym_err
);
    localparam int               WORD_W  = SYM_W * SYM_PER_WORD;
    localparam int               CNT_W   = $clog2(SYM_PER_WORD + 1);
    localparam logic [SYM_W:0]   SYM_LIM = (SYM_W + 1)'(SYM_MAX);
    localparam logic [SYM_W-1:0] IDLE    = SYM_W'(IDLE_SYM);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(SYM_PER_WORD - 1);

    tx_state_t         state_q, state_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDW-1:0]    ptr_q, ptr_d, grant_id_q, grant_id_d;
    logic [SYM_W-1:0]  enc_data_q, enc_data_d;
    logic              enc_sof_q, enc_sof_d, enc_active_q, enc_active_d, sym_err_q, sym_err_d;
    logic [IDW-1:0]    arb_id;
    logic [WORD_W-1:0] word;
    logic [SYM_W-1:0]  next_sym, pay_sym;
    logic              arb_en, accept, illegal, shifting;

    assign arb_en = (state_q == ST_IDLE) || (state_q == ST_PAY && cnt_q == LAST);

    tns_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_arb (
        .req (req_valid),
        .ptr (ptr_q),
        .en  (arb_en),
        .gnt (req_ready),
        .id  (arb_id)
    );

    always_comb begin
        accept   = |req_ready;
        word     = req_data[arb_id*WORD_W +: WORD_W];
        // only a headerless accept emits straight from the incoming word
        next_sym = accept ? word[SYM_W-1:0] : shift_q[SYM_W-1:0];
        illegal  = {1'b0, next_sym} >= SYM_LIM;
        pay_sym  = illegal ? IDLE : next_sym;
        shifting = state_q == ST_HDR || (state_q == ST_PAY && cnt_q != LAST);
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        grant_id_d = grant_id_q;
        enc_data_d = IDLE;
        enc_sof_d  = accept;
        sym_err_d  = sym_err_q;
        if (accept) begin
            grant_id_d = arb_id;
            ptr_d      = (arb_id == IDW'(NUM_REQ - 1)) ? '0 : arb_id + 1'b1;
            cnt_d      = '0;
            state_d    = HDR_EN ? ST_HDR : ST_PAY;
            shift_d    = HDR_EN ? word : word >> SYM_W;
            enc_data_d = HDR_EN ? SYM_W'(arb_id) : pay_sym;
            sym_err_d  = sym_err_q | (!HDR_EN && illegal);
        end else if (shifting) begin
            state_d    = ST_PAY;
            shift_d    = shift_q >> SYM_W;
            cnt_d      = (state_q == ST_HDR) ? '0 : cnt_q + 1'b1;
            enc_data_d = pay_sym;
            sym_err_d  = sym_err_q | illegal;
        end else begin
            state_d    = ST_IDLE;
        end
        enc_active_d = state_d != ST_IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            ptr_q        <= '0;
            grant_id_q   <= '0;
            enc_data_q   <= IDLE;
            enc_sof_q    <= 1'b0;
            enc_active_q <= 1'b0;
            sym_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            ptr_q        <= ptr_d;
            grant_id_q   <= grant_id_d;
            enc_data_q   <= enc_data_d;
            enc_sof_q    <= enc_sof_d;
            enc_active_q <= enc_active_d;
            sym_err_q    <= sym_err_d;
        end
    end

    assign enc_data   = enc_data_q;
    assign enc_sof    = enc_sof_q;
    assign enc_active = enc_active_q;
    assign grant_id   = grant_id_q;
    assign sym_err    = sym_err_q;
endmodule

// File: tb/tb_tns_tx_scheduler.sv
// tb_tns_tx_scheduler: frame-queue model checks a header and a headerless build every cycle
module tb_tns_tx_scheduler;
    localparam int NR = 4;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [47:0] req_data;
    logic [3:0]  rdy[2];
    logic [2:0]  ed[2];
    logic        sof[2], act[2], err[2];
    logic [1:0]  gid[2];
    int          tests = 0, fails = 0;
    bit          armed = 1'b0;

    int m_data[2], m_gid[2], m_ptr[2], pn[2];
    bit m_sof[2], m_act[2], m_err[2];
    int pq[2][0:7];
    int pick, rv, w;
    longint rd;

    always #5 clk = ~clk;

    tns_tx_scheduler #(.HDR_EN(1'b1)) dut_hdr (
        .clock(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(rdy[0]), .enc_data(ed[0]), .enc_sof(sof[0]), .enc_active(act[0]),
        .grant_id(gid[0]), .sym_err(err[0]));

    tns_tx_scheduler #(.HDR_EN(1'b0)) dut_raw (
        .clock(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(rdy[1]), .enc_data(ed[1]), .enc_sof(sof[1]), .enc_active(act[1]),
        .grant_id(gid[1]), .sym_err(err[1]));

    task automatic chk(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
        end
    endtask

    task automatic emit(input int m);
        int s;
        if (pn[m] == 0) begin
            m_data[m] = 0;
            m_act[m]  = 1'b0;
            return;
        end
        s = pq[m][0];
        for (int i = 0; i < 7; i++) pq[m][i] = pq[m][i+1];
        pn[m]--;
        m_act[m]  = 1'b1;
        m_data[m] = (s >= 6) ? 0 : s;
        if (s >= 6) m_err[m] = 1'b1;
    endtask

    // Model: a frame is a list of symbols; arbitration happens whenever no symbols remain queued.
    always @(negedge clk) begin
        if (armed) begin
            for (int m = 0; m < 2; m++) begin
                chk($sformatf("enc_data[%0d]", m), int'(ed[m]), m_data[m]);
                chk($sformatf("enc_sof[%0d]", m), int'(sof[m]), int'(m_sof[m]));
                chk($sformatf("enc_active[%0d]", m), int'(act[m]), int'(m_act[m]));
                chk($sformatf("grant_id[%0d]", m), int'(gid[m]), m_gid[m]);
                chk($sformatf("sym_err[%0d]", m), int'(err[m]), int'(m_err[m]));
                pick = -1;
                rv   = int'(req_valid);
                if (pn[m] == 0)
                    for (int i = 0; i < NR; i++)
                        if (pick < 0 && ((rv >> ((m_ptr[m] + i) % NR)) & 1) == 1) pick = (m_ptr[m] + i) % NR;
                chk($sformatf("req_ready[%0d]", m), int'(rdy[m]), pick < 0 ? 0 : (1 << pick));
                if (reset) begin
                    pn[m] = 0; m_data[m] = 0; m_sof[m] = 1'b0; m_act[m] = 1'b0;
                    m_gid[m] = 0; m_err[m] = 1'b0; m_ptr[m] = 0;
                end else begin
                    m_sof[m] = pick >= 0;
                    if (pick >= 0) begin
                        rd = longint'(req_data);
                        w  = int'((rd >> (pick * 12)) & 64'hfff);
                        pn[m] = 0;
                        if (m == 0) begin pq[m][0] = pick; pn[m] = 1; end
                        for (int k = 0; k < 4; k++) begin
                            pq[m][pn[m]] = (w >> (3 * k)) & 7;
                            pn[m]++;
                        end
                        m_gid[m] = pick;
                        m_ptr[m] = (pick + 1) % NR;
                    end
                    emit(m);
                end
            end
        end
    end

    function automatic logic [47:0] wd(input int slot, input int s0, input int s1, input int s2, input int s3);
        logic [11:0] x = {3'(s3), 3'(s2), 3'(s1), 3'(s0)};
        return 48'(x) << (12 * slot);
    endfunction

    task automatic drv(input logic [3:0] v, input logic [47:0] d, input logic r);
        req_valid = v;
        req_data  = d;
        reset     = r;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int e0[6] = '{0, 1, 2, 3, 4, 0};
    int e1[6] = '{1, 2, 3, 4, 0, 0};
    logic        r;
    logic [3:0]  v;
    logic [47:0] d;

    initial begin
        for (int m = 0; m < 2; m++) begin
            pn[m] = 0; m_data[m] = 0; m_gid[m] = 0; m_ptr[m] = 0;
            m_sof[m] = 1'b0; m_act[m] = 1'b0; m_err[m] = 1'b0;
        end
        drv(4'h0, 48'h0, 1'b1); tick(); armed = 1'b1; tick();
        chk("rst_enc_data", int'(ed[0]), 0);
        chk("rst_active", int'(act[0]), 0);
        chk("rst_ready", int'(rdy[0]), 0);
        chk("rst_grant", int'(gid[0]), 0);
        chk("rst_err", int'(err[0]), 0);

        drv(4'b0001, wd(0, 1, 2, 3, 4), 1'b0);
        chk("single_ready", int'(rdy[0]), 1);
        tick();
        drv(4'h0, 48'h0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            chk("single_data", int'(ed[0]), e0[k]);
            chk("single_sof", int'(sof[0]), int'(k == 0));
            chk("single_active", int'(act[0]), int'(k < 5));
            chk("raw_data", int'(ed[1]), e1[k]);
            chk("raw_sof", int'(sof[1]), int'(k == 0));
            chk("raw_active", int'(act[1]), int'(k < 4));
            tick();
        end

        drv(4'h0, 48'h0, 1'b1); tick();
        drv(4'hf, wd(3, 4, 4, 4, 4) | wd(2, 3, 3, 3, 3) | wd(1, 2, 2, 2, 2) | wd(0, 1, 1, 1, 1), 1'b0);
        tick();
        for (int c = 0; c < 25; c++) begin
            chk("b2b_active", int'(act[0]), 1);
            chk("b2b_sof", int'(sof[0]), int'(c % 5 == 0));
            if (c % 5 == 0) chk("b2b_hdr", int'(ed[0]), (c / 5) % 4);
            tick();
        end

        drv(4'h0, 48'h0, 1'b1); tick();
        drv(4'b0100, wd(2, 5, 4, 3, 2), 1'b0); tick();
        drv(4'h0, 48'h0, 1'b0); repeat (4) tick();
        drv(4'b1010, wd(3, 1, 1, 1, 1) | wd(1, 2, 2, 2, 2), 1'b0);
        chk("rr_ready_3", int'(rdy[0]), 8);
        tick();
        chk("rr_hdr_3", int'(ed[0]), 3);
        repeat (4) begin
            chk("rr_hold", int'(rdy[0]), 0);
            tick();
        end
        chk("rr_ready_1", int'(rdy[0]), 2);
        tick();
        chk("rr_hdr_1", int'(ed[0]), 1);
        chk("rr_sof_1", int'(sof[0]), 1);
        drv(4'h0, 48'h0, 1'b0);

        drv(4'h0, 48'h0, 1'b1); tick();
        drv(4'b0001, wd(0, 1, 7, 2, 3), 1'b0); tick();
        drv(4'h0, 48'h0, 1'b0);
        chk("err_pre", int'(err[0]), 0);
        tick();
        chk("err_raw_sub", int'(ed[1]), 0);
        chk("err_raw_flag", int'(err[1]), 1);
        chk("err_pre2", int'(err[0]), 0);
        tick();
        chk("err_sub", int'(ed[0]), 0);
        chk("err_flag", int'(err[0]), 1);
        chk("err_active", int'(act[0]), 1);
        repeat (4) tick();
        drv(4'b0010, wd(1, 1, 2, 3, 4), 1'b0); tick();
        drv(4'h0, 48'h0, 1'b0); repeat (6) tick();
        chk("err_sticky", int'(err[0]), 1);
        drv(4'h0, 48'h0, 1'b1); tick();
        chk("err_cleared", int'(err[0]), 0);

        drv(4'b0001, wd(0, 1, 2, 3, 4), 1'b0); tick();
        drv(4'h0, 48'h0, 1'b0); repeat (3) tick();
        chk("mid_pay", int'(ed[0]), 3);
        drv(4'h0, 48'h0, 1'b1); tick();
        chk("mid_rst_data", int'(ed[0]), 0);
        chk("mid_rst_active", int'(act[0]), 0);
        chk("mid_rst_ready", int'(rdy[0]), 0);
        drv(4'b1000, wd(3, 5, 5, 5, 5), 1'b0);
        chk("mid_rst_rr", int'(rdy[0]), 8);
        tick();
        chk("mid_rst_hdr", int'(ed[0]), 3);
        drv(4'h0, 48'h0, 1'b0); repeat (6) tick();

        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(0, 199) == 0;
            for (int s = 0; s < 16; s++)
                d[s*3 +: 3] = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
            v = r ? 4'h0 : (c < 2000 ? 4'($urandom) : 4'hf);
            drv(v, d, r);
            tick();
        end
        drv(4'h0, 48'h0, 1'b0); tick(); tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
